exec_result_buffer: RTL and testbench
=====================================

# exec_result_buffer

Two-entry result buffer between the EX-stage bitwise logic unit and the writeback stage of the MIPS 16-bit processor. It captures each 32-bit logic result and its destination register tag through a valid/ready handshake, derives zero and negative flags on capture, and presents results in order to writeback. It decouples writeback stalls from the combinational ALU path and supports a pipeline flush.

## Interface
- WIDTH, 32, result datapath width
- TAG_W, 4, destination register tag width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; discards all buffered entries
- in_valid  in  1  upstream result valid
- in_ready  out  1  buffer can accept an entry this cycle
- in_result  in  WIDTH  logic-unit result (e.g. in1 & in2)
- in_rd  in  TAG_W  destination register tag
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback accepts head entry
- out_result  out  WIDTH  head entry result
- out_rd  out  TAG_W  head entry tag
- out_zero  out  1  head result == 0
- out_neg  out  1  head result bit WIDTH-1
- count  out  2  occupancy, 0..2

## Operation
- Storage: 2 entries {result, rd, zero, neg}, circular read/write pointers (1 bit each) plus 2-bit count.
- Push = in_valid & in_ready & !flush. Pop = out_valid & out_ready & !flush.
- in_ready = (count != 2). It is a function of registered count only and never depends on out_ready. When full, no push occurs even if a pop happens the same cycle.
- out_valid = (count != 0). The out_* fields come from the entry at the read pointer.
- Flags are computed from in_result at capture: zero = ~|in_result, neg = in_result[WIDTH-1]. Both are stored with the entry.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop (count 1): unchanged, the old head leaves and the new entry becomes head
  - neither: unchanged
- Pointers wrap modulo 2.
- Flush has priority over push and pop. On the next edge, count, write pointer and read pointer go to 0. An in_valid presented in the flush cycle is dropped. The out_ready value in the flush cycle is irrelevant.
- Ordering is strict FIFO. No entry is duplicated, reordered or lost except by flush or reset.

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0, pointers = 0, all entry storage = 0
  - out_valid = 0, out_result = 0, out_rd = 0, out_zero = 0, out_neg = 0
  - in_ready = 1, but nothing is captured while rst_n is low
- Reset deassertion mid-transfer: any entries are lost. The first edge after release may accept a push.
- Latency: a push on edge N gives out_valid = 1 with that entry after edge N when the buffer was empty. There is no combinational in-to-out path.
- Throughput: 1 entry/cycle sustained when out_ready is held high (count toggles 0→1 and stays at 1).
- Stall: while out_valid & !out_ready, out_result, out_rd, out_zero and out_neg stay stable.
- Full: count = 2 gives in_ready = 0 for at least one cycle. A pop in that cycle gives count = 1 and in_ready = 1 after the edge.
- Empty: count = 0 gives out_valid = 0. out_* hold the last head storage contents, which must not be interpreted.
- Flush asserted for consecutive cycles: the buffer stays empty and no push occurs.

## Test plan
- Reset then single push: in_result = 0x0000_F0F0, in_rd = 3, out_ready = 0 → after 1 edge out_valid = 1, out_result = 0x0000_F0F0, out_rd = 3, out_zero = 0, out_neg = 0, count = 1.
- Fill and stall: push 0x8000_0000 (rd 1) then 0x0000_0000 (rd 2), out_ready = 0 → count = 2, in_ready = 0, head shows neg = 1. A third in_valid is not accepted. Raise out_ready → 0x8000_0000 pops, then 0x0 with zero = 1.
- Streaming: 16 back-to-back pushes of incrementing values with out_ready = 1 → 16 pops in order, one per cycle after a 1-cycle fill, count never exceeds 1.
- Simultaneous push/pop at count = 1 → count stays 1, new entry becomes head next cycle, and the write pointer wrap is exercised.
- Flush: with count = 2, assert flush together with in_valid = 1 and out_ready = 1 → next cycle count = 0, out_valid = 0, and neither the incoming entry nor either buffered entry ever appears at the output.
- Asynchronous reset mid-stream: drop rst_n between clock edges while count = 2 → outputs clear immediately without a clock edge. After release, count = 0 and in_ready = 1.

Source files
------------

// File: rtl/exec_result_buffer.sv
// Two-entry in-order result buffer between the logic unit and writeback; a push is visible at the output one edge later.
// in_ready depends only on registered occupancy, never on out_ready; a full buffer refuses pushes even while popping.
module exec_result_buffer #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_zero,
    output logic             out_neg,
    output logic [1:0]       count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] rd;
        logic             zero;
        logic             neg;
    } entry_t;

    entry_t     r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic   w_push;
    logic   w_pop;
    entry_t w_new;
    entry_t w_head;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign count     = r_count;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    // Flags are computed once at capture so writeback sees them without extra logic.
    assign w_new.result = in_result;
    assign w_new.rd     = in_rd;
    assign w_new.zero   = ~|in_result;
    assign w_new.neg    = in_result[WIDTH-1];

    assign w_head     = r_mem[r_rptr];
    assign out_result = w_head.result;
    assign out_rd     = w_head.rd;
    assign out_zero   = w_head.zero;
    assign out_neg    = w_head.neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_new;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_result_buffer.sv
// Bench for exec_result_buffer: queue-based reference model compared every cycle, plus literal expectations.
module tb_exec_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_zero;
    logic        out_neg;
    logic [1:0]  count;

    int n_checks = 0;
    int n_err    = 0;

    exec_result_buffer #(.WIDTH(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of at most two entries.
    typedef struct {
        logic [31:0] res;
        logic [3:0]  rd;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   sz;
    bit   do_push;
    bit   do_pop;

    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else begin
                sz      = q.size();
                do_push = in_valid && (sz < 2);
                do_pop  = out_ready && (sz > 0);
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    e.res = in_result;
                    e.rd  = in_rd;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge rst_n) q.delete();

    logic [31:0] h;
    always @(negedge clk) begin
        chk("count", {30'd0, count}, q.size());
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() > 0) begin
            h = q[0].res;
            chk("out_result", out_result, h);
            chk("out_rd", {28'd0, out_rd}, {28'd0, q[0].rd});
            chk("out_zero", {31'd0, out_zero}, {31'd0, h == 32'd0});
            chk("out_neg", {31'd0, out_neg}, {31'd0, h[31]});
        end
    end

    task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] t,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_result = r;
        in_rd     = t;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 4'd7, 1'b0, 1'b0);
        #12;
        chk("rst_count", {30'd0, count}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {28'd0, out_rd}, 32'd0);
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;

        // Single push into empty buffer
        drive(1'b1, 32'h0000_F0F0, 4'd3, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_result", out_result, 32'h0000_F0F0);
        chk("t1_rd", {28'd0, out_rd}, 32'd3);
        chk("t1_zero", {31'd0, out_zero}, 32'd0);
        chk("t1_neg", {31'd0, out_neg}, 32'd0);
        chk("t1_count", {30'd0, count}, 32'd1);
        drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        cyc();
        chk("t1_drained", {30'd0, count}, 32'd0);

        // Fill and stall
        drive(1'b1, 32'h8000_0000, 4'd1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h0000_0000, 4'd2, 1'b0, 1'b0);
        cyc();
        chk("t2_count", {30'd0, count}, 32'd2);
        chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t2_neg", {31'd0, out_neg}, 32'd1);
        drive(1'b1, 32'h0000_1234, 4'd5, 1'b0, 1'b0);
        cyc();
        chk("t2_full_count", {30'd0, count}, 32'd2);
        chk("t2_full_head", out_result, 32'h8000_0000);
        drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        cyc();
        chk("t2_pop_count", {30'd0, count}, 32'd1);
        chk("t2_pop_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t2_second_zero", {31'd0, out_zero}, 32'd1);
        chk("t2_second_rd", {28'd0, out_rd}, 32'd2);
        cyc();
        chk("t2_empty", {31'd0, out_valid}, 32'd0);

        // Streaming with out_ready held high
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h100 + i, i[3:0], 1'b1, 1'b0);
            cyc();
            chk("t3_count", {30'd0, count}, 32'd1);
            chk("t3_head", out_result, 32'h100 + i);
        end
        drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        cyc();
        chk("t3_drained", {30'd0, count}, 32'd0);

        // Simultaneous push/pop at count 1
        drive(1'b1, 32'hAAAA_0001, 4'd9, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'hBBBB_0002, 4'd10, 1'b1, 1'b0);
        cyc();
        chk("t4_count", {30'd0, count}, 32'd1);
        chk("t4_head", out_result, 32'hBBBB_0002);
        chk("t4_rd", {28'd0, out_rd}, 32'd10);

        // Flush with full buffer, incoming push and pop request
        drive(1'b1, 32'hCCCC_0003, 4'd11, 1'b0, 1'b0);
        cyc();
        chk("t5_full", {30'd0, count}, 32'd2);
        drive(1'b1, 32'hDDDD_0004, 4'd12, 1'b1, 1'b1);
        cyc();
        chk("t5_count", {30'd0, count}, 32'd0);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hEEEE_0000 + i, 4'd13, 1'b0, 1'b1);
            cyc();
            chk("t5_hold_flush", {30'd0, count}, 32'd0);
        end
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        cyc();
        chk("t5_after", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with buffer full
        drive(1'b1, 32'h1111_1111, 4'd1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h8222_2222, 4'd2, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        chk("t6_full", {30'd0, count}, 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count", {30'd0, count}, 32'd0);
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_result", out_result, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_rel_count", {30'd0, count}, 32'd0);
        chk("t6_rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            logic [1:0]  mode;
            mode = 2'($urandom_range(0, 3));
            case (mode)
                2'd0:    r = 32'd0;
                2'd1:    r = 32'h8000_0000 | $urandom;
                default: r = $urandom;
            endcase
            drive(1'($urandom_range(0, 3) != 0), r, 4'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            cyc();
        end
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
